// File: rtl/rgb_led_pwm_sched.sv
// rgb_led_pwm_sched
// Time-multiplexed PWM driver for four RGB LEDs (12 channels). Only one LED
// owns the output at a time, round-robin, and all lit channels share one
// software-programmable brightness. Per-channel enables pass through from GPIO
// but are snapshotted once per slot, so an LED never changes mid-slot.
module rgb_led_pwm_sched #(
  parameter int unsigned PRESCALE_DIV = 100,
  parameter logic [7:0]  DUTY_RESET   = 8'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] en_i,
  input  logic [7:0]  duty_i,
  input  logic        duty_load_i,
  output logic [11:0] led_o,
  output logic [1:0]  slot_o,
  output logic        frame_o
);

  localparam int NUM_LEDS    = 4;
  localparam int CH_PER_LED  = 3;
  localparam int NUM_CH      = NUM_LEDS * CH_PER_LED;

  // One PWM tick every PRESCALE_DIV clocks
  logic tick;

  // Free-running 8-bit PWM phase and the slot (LED index) owning the outputs
  logic [7:0]        pwm_cnt_reg;
  logic [1:0]        slot_reg;

  // Brightness: shadow holds the last software write, act is what the
  // comparator uses; act only moves on a slot boundary so a pulse is never cut
  logic [7:0]        duty_shadow_reg;
  logic [7:0]        duty_act_reg;

  // Enables sampled at each slot boundary
  logic [NUM_CH-1:0] en_q_reg;

  // Registered outputs
  logic [NUM_CH-1:0] led_reg;
  logic [NUM_CH-1:0] led_next;
  logic              frame_reg;

  // Slot boundary: last tick of the 256-tick PWM period
  logic boundary;
  logic frame_next;
  logic lit_phase;

  generate
    if (PRESCALE_DIV <= 1) begin : g_no_presc
      // Every clock is a tick; no prescaler state needed
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int PW = $clog2(PRESCALE_DIV);
      localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

      logic [PW-1:0] presc_reg;

      // Prescaler counts 0..PRESCALE_DIV-1 and wraps on its terminal count
      always_ff @(posedge clk) begin
        if (rst) begin
          presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
          presc_reg <= '0;
        end else begin
          presc_reg <= presc_reg + 1'b1;
        end
      end

      assign tick = (presc_reg == PRESC_LAST);
    end
  endgenerate

  assign boundary   = tick && (pwm_cnt_reg == 8'hFF);
  assign frame_next = boundary && (slot_reg == 2'd3);
  assign lit_phase  = (pwm_cnt_reg < duty_act_reg);

  // PWM phase advances on each tick; the slot advances once per PWM period
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg <= 8'd0;
      slot_reg    <= 2'd0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      if (boundary) begin
        slot_reg <= slot_reg + 2'd1;
      end
    end
  end

  // Brightness double-buffer; a load landing exactly on a boundary writes
  // straight through so it is not delayed by a whole extra slot
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_reg <= DUTY_RESET;
      duty_act_reg    <= DUTY_RESET;
    end else begin
      if (duty_load_i) begin
        duty_shadow_reg <= duty_i;
      end
      if (boundary) begin
        duty_act_reg <= duty_load_i ? duty_i : duty_shadow_reg;
      end
    end
  end

  // Enable snapshot, taken for all channels at once on every boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q_reg <= '0;
    end else if (boundary) begin
      en_q_reg <= en_i;
    end
  end

  // Per-LED gating: only the LED that owns the current slot may light,
  // and only while the PWM phase is below the active duty
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic owns_slot;
      assign owns_slot = (slot_reg == 2'(gi));
      assign led_next[CH_PER_LED*gi +: CH_PER_LED] =
        (owns_slot && lit_phase) ? en_q_reg[CH_PER_LED*gi +: CH_PER_LED]
                                 : {CH_PER_LED{1'b0}};
    end
  endgenerate

  // Output register: LED drive and frame-start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg   <= '0;
      frame_reg <= 1'b0;
    end else begin
      led_reg   <= led_next;
      frame_reg <= frame_next;
    end
  end

  assign led_o   = led_reg;
  assign slot_o  = slot_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_rgb_led_pwm_sched.sv
// tb_rgb_led_pwm_sched
// Directed scenarios plus randomized enables/loads, checked every cycle
// against a timeline model: with one tick per clock, cycle t since reset has
// PWM phase t mod 256 and slot (t / 256) mod 4.
module tb_rgb_led_pwm_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] en_i = 12'h000;
  logic [7:0]  duty_i = 8'h00;
  logic        duty_load_i = 1'b0;
  logic [11:0] led_o;
  logic [1:0]  slot_o;
  logic        frame_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: cycle index since reset, snapshotted enables, duties
  int          m_t      = 0;
  logic [11:0] m_en     = 12'h000;
  int          m_duty   = 32;
  int          m_shadow = 32;

  rgb_led_pwm_sched #(
    .PRESCALE_DIV(1),
    .DUTY_RESET  (8'd32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .duty_i     (duty_i),
    .duty_load_i(duty_load_i),
    .led_o      (led_o),
    .slot_o     (slot_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
  endtask

  // Advance one clock: predict outputs from the current cycle, update the
  // model for the edge, then compare after the edge
  task automatic step();
    int          pwm;
    int          slot;
    int          groups;
    logic        bnd;
    logic [11:0] led_exp;
    logic        frm_exp;
    pwm  = m_t % 256;
    slot = (m_t / 256) % 4;
    led_exp = 12'h000;
    for (int b = 0; b < 12; b++)
      if ((b / 3) == slot && m_en[b] && pwm < m_duty) led_exp[b] = 1'b1;
    bnd     = (pwm == 255);
    frm_exp = bnd && (slot == 3);
    if (rst) begin
      m_t = 0; m_en = 12'h000; m_duty = 32; m_shadow = 32;
      led_exp = 12'h000; frm_exp = 1'b0;
    end else begin
      if (bnd) begin
        m_en   = en_i;
        m_duty = duty_load_i ? int'(duty_i) : m_shadow;
      end
      if (duty_load_i) m_shadow = int'(duty_i);
      m_t++;
    end
    @(posedge clk);
    #1;
    chk("led", led_o, led_exp);
    chk("slot", 12'(slot_o), 12'((m_t / 256) % 4));
    chk("frame", 12'(frame_o), 12'(frm_exp));
    groups = 0;
    for (int k = 0; k < 4; k++) if (led_o[3*k +: 3] != 3'b000) groups++;
    chk("onehot_led", 12'(groups <= 1), 12'd1);
    duty_load_i = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (m_t < target) step();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] d);
    duty_i = d;
    duty_load_i = 1'b1;
    step();
  endtask

  initial begin
    // Scenario 1: reset with all enables high
    en_i = 12'hFFF;
    do_reset(3);
    chk("rst_led", led_o, 12'h000);
    chk("rst_slot", 12'(slot_o), 12'h000);
    run_to(256);
    chk("c256_dark", led_o, 12'h000);
    run_to(257);
    chk("c257_led1_on", led_o, 12'h038);
    run_to(288);
    chk("c288_led1_on", led_o, 12'h038);
    run_to(289);
    chk("c289_led1_off", led_o, 12'h000);

    // Scenario 2: brightness 0x40 on blue of LED 0
    do_reset(1);
    en_i = 12'h001;
    run_to(10);
    load(8'h40);
    run_to(1024);
    chk("frame_1024", 12'(frame_o), 12'h001);
    run_to(1025);
    chk("c1025_on", led_o, 12'h001);
    run_to(1088);
    chk("c1088_on", led_o, 12'h001);
    run_to(1089);
    chk("c1089_off", led_o, 12'h000);
    run_to(1300);

    // Scenario 3: duty extremes
    do_reset(1);
    en_i = 12'hFFF;
    load(8'h00);
    run_to(256 + 1024 + 4);
    load(8'hFF);
    run_to(2048 + 255);
    chk("d255_lit", led_o, 12'h007);
    run_to(2048 + 256);
    chk("d255_dark_last", led_o, 12'h000);
    run_to(2048 + 1100);

    // Scenario 4: load timing, mid-slot then on a boundary
    do_reset(1);
    en_i = 12'hFFF;
    run_to(300);
    load(8'h10);
    run_to(767);
    load(8'h80);
    run_to(896);
    chk("wt_c896_on", led_o, 12'hE00);
    run_to(897);
    chk("wt_c897_off", led_o, 12'h000);
    run_to(1100);

    // Scenario 5: three frames of randomized enables and loads
    do_reset(1);
    for (int i = 0; i < 3 * 1024 + 8; i++) begin
      if ($urandom_range(0, 3) == 0) en_i = 12'($urandom);
      if ((m_t % 256 == 255 && $urandom_range(0, 1) == 0) || $urandom_range(0, 63) == 0)
        load(8'($urandom));
      else
        step();
    end

    // Scenario 6: reset mid-slot, sequence restarts
    do_reset(1);
    en_i = 12'hFFF;
    load(8'hC0);
    run_to(600);
    do_reset(1);
    chk("midrst_led", led_o, 12'h000);
    chk("midrst_slot", 12'(slot_o), 12'h000);
    run_to(257);
    chk("midrst_c257", led_o, 12'h038);
    run_to(289);
    chk("midrst_c289", led_o, 12'h000);
    run_to(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
